psc_transfer_sequencer: RTL and testbench

- Controller that schedules and sequences one shared bit-sliced Parallel/Serial converter among N_REQ requesters (PE-array load/drain engines).
- Round-robin arbitration of transfer requests; drives the converter's mode/start and waits for its finish pulse.
- Reports per-transfer completion and a timeout error if the converter does not respond.
- Sits between the PE-array control logic and the converter instance.

---
 rtl/psc_seq_pkg.sv | 23 ++
 rtl/psc_transfer_sequencer_rr_arbiter.sv | 39 +++
 rtl/psc_transfer_sequencer.sv | 157 +++++++++++++++
 tb/tb_psc_transfer_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/psc_seq_pkg.sv
// Shared constants, state encoding and sizing helper for the Parallel/Serial
// converter transfer sequencer.
package psc_seq_pkg;

    localparam logic [1:0] MODE_SHIFT_OUT = 2'd0;
    localparam logic [1:0] MODE_SHIFT_IN  = 2'd1;
    localparam logic [1:0] MODE_PLOAD     = 2'd2;
    localparam logic [1:0] MODE_RSVD      = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

    // Nominal conv_start -> conv_finish distance: one cycle per slice plus
    // the converter's load and flush cycles.
    function automatic int exp_cycles(input int length, input int slice_size);
        return length / slice_size + 2;
    endfunction

endpackage

// File: rtl/psc_transfer_sequencer_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
// The pointer itself is owned by the sequencer.
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    input  logic                     en,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] gnt_id,
    output logic                     valid
);

    localparam int ID_W = $clog2(N_REQ);

    logic [ID_W:0] idx;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        valid  = 1'b0;
        idx    = '0;
        if (en) begin
            for (int i = 0; i < N_REQ; i++) begin
                // idx is one bit wider so ptr+i never overflows before the wrap
                idx = {1'b0, ptr} + (ID_W + 1)'(i);
                if (idx >= (ID_W + 1)'(N_REQ)) begin
                    idx = idx - (ID_W + 1)'(N_REQ);
                end
                if (!valid && req[idx[ID_W-1:0]]) begin
                    valid                = 1'b1;
                    gnt[idx[ID_W-1:0]]   = 1'b1;
                    gnt_id               = idx[ID_W-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/psc_transfer_sequencer.sv
// Schedules one shared bit-sliced Parallel/Serial converter among N_REQ
// requesters: round-robin pick, issue, wait for finish or timeout, report.
module psc_transfer_sequencer
    import psc_seq_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int LENGTH     = 32,
    parameter int SLICE_SIZE = 4,
    parameter int EXP_CYC    = exp_cycles(LENGTH, SLICE_SIZE),
    parameter int TIMEOUT    = 2 * EXP_CYC
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req,
    input  logic [2*N_REQ-1:0]         req_op,
    output logic [N_REQ-1:0]           grant,
    output logic [$clog2(N_REQ)-1:0]   active_id,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [1:0]                 conv_mode,
    output logic                       conv_start,
    input  logic                       conv_finish
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    // The check looks at the pre-increment value, so DONE lands exactly
    // TIMEOUT cycles after conv_start.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 2);

    seq_state_e        state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [1:0]        op_q, op_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              arb_en;
    logic [N_REQ-1:0]  arb_gnt;
    logic [ID_W-1:0]   arb_id;
    logic              arb_valid;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req    (req),
        .ptr    (ptr_q),
        .en     (arb_en),
        .gnt    (arb_gnt),
        .gnt_id (arb_id),
        .valid  (arb_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            gnt_q   <= '0;
            op_q    <= MODE_SHIFT_OUT;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            gnt_q   <= gnt_d;
            op_q    <= op_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        id_d       = id_q;
        gnt_d      = gnt_q;
        op_d       = op_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        arb_en     = (state_q == IDLE);

        grant      = '0;
        active_id  = '0;
        busy       = (state_q != IDLE);
        done       = 1'b0;
        err        = 1'b0;
        conv_mode  = MODE_SHIFT_OUT;
        conv_start = 1'b0;

        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    id_d    = arb_id;
                    gnt_d   = arb_gnt;
                    op_d    = req_op[2*arb_id +: 2];
                    ptr_d   = (arb_id == ID_W'(N_REQ - 1)) ? '0 : arb_id + 1'b1;
                    err_d   = 1'b0;
                    state_d = ISSUE;
                end
            end

            ISSUE: begin
                grant     = gnt_q;
                active_id = id_q;
                case (op_q)
                    MODE_PLOAD: begin
                        conv_mode = MODE_PLOAD;
                        state_d   = DONE;
                    end
                    MODE_RSVD: begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                    default: begin
                        conv_mode  = op_q;
                        conv_start = 1'b1;
                        cnt_d      = '0;
                        state_d    = RUN;
                    end
                endcase
            end

            RUN: begin
                grant     = gnt_q;
                active_id = id_q;
                conv_mode = op_q;
                cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                // A finish seen in the timeout cycle still counts as success
                if (conv_finish) begin
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (cnt_q >= CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end

            DONE: begin
                grant     = gnt_q;
                active_id = id_q;
                done      = 1'b1;
                err       = err_q;
                state_d   = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_psc_transfer_sequencer.sv
// Directed, table-driven bench for psc_transfer_sequencer with hand-computed
// cycle-by-cycle expectations and a few multi-cycle sequences.
module tb_psc_transfer_sequencer;
    import psc_seq_pkg::*;

    localparam int N_REQ      = 4;
    localparam int LENGTH     = 32;
    localparam int SLICE_SIZE = 4;
    localparam int NVEC       = 21;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [7:0] req_op;
    logic       conv_finish;
    logic [3:0] grant;
    logic [1:0] active_id;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] conv_mode;
    logic       conv_start;

    typedef struct packed {
        logic [3:0] grant;
        logic [1:0] active_id;
        logic       busy;
        logic       done;
        logic       err;
        logic [1:0] conv_mode;
        logic       conv_start;
    } out_t;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [7:0] op;
        logic       fin;
        out_t       exp;
    } vec_t;

    vec_t vecs [NVEC];
    int   applied     = 0;
    int   miscompares = 0;

    psc_transfer_sequencer #(
        .N_REQ      (N_REQ),
        .LENGTH     (LENGTH),
        .SLICE_SIZE (SLICE_SIZE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_op      (req_op),
        .grant       (grant),
        .active_id   (active_id),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .conv_mode   (conv_mode),
        .conv_start  (conv_start),
        .conv_finish (conv_finish)
    );

    always #5 clk = ~clk;

    function automatic out_t mk(input logic [3:0] g, input logic [1:0] id, input logic b,
                                input logic d, input logic e, input logic [1:0] m, input logic s);
        out_t o;
        o.grant      = g;
        o.active_id  = id;
        o.busy       = b;
        o.done       = d;
        o.err        = e;
        o.conv_mode  = m;
        o.conv_start = s;
        return o;
    endfunction

    function automatic vec_t mkVec(input logic r, input logic [3:0] rq, input logic [7:0] op,
                                   input logic f, input out_t e);
        vec_t v;
        v.rst = r;
        v.req = rq;
        v.op  = op;
        v.fin = f;
        v.exp = e;
        return v;
    endfunction

    task automatic applyStimulus(input logic r, input logic [3:0] rq, input logic [7:0] op,
                                 input logic f);
        @(posedge clk);
        #1;
        reset       = r;
        req         = rq;
        req_op      = op;
        conv_finish = f;
    endtask

    task automatic checkOutput(input out_t exp, input string name);
        out_t act;
        @(negedge clk);
        act = {grant, active_id, busy, done, err, conv_mode, conv_start};
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got grant=%b id=%0d busy=%b done=%b err=%b mode=%0d start=%b, expected grant=%b id=%0d busy=%b done=%b err=%b mode=%0d start=%b",
                     name, act.grant, act.active_id, act.busy, act.done, act.err, act.conv_mode,
                     act.conv_start, exp.grant, exp.active_id, exp.busy, exp.done, exp.err,
                     exp.conv_mode, exp.conv_start);
        end
    endtask

    // Single requester transfer; k=0 is the IDLE cycle where req is seen,
    // k=1 is ISSUE, DONE at doneAt. finAt<0 means the converter never answers.
    task automatic runTransfer(input int id, input logic [1:0] op, input int finAt,
                               input int doneAt, input logic expErr, input string tag);
        logic [3:0] g;
        logic [3:0] rq;
        logic [7:0] opv;
        logic [1:0] issueMode;
        out_t       e;
        g         = 4'(1) << id;
        opv       = 8'(op) << (2 * id);
        issueMode = (op == MODE_PLOAD) ? MODE_PLOAD : (op == MODE_RSVD) ? 2'd0 : op;
        for (int k = 0; k <= doneAt + 1; k++) begin
            rq = (k < doneAt) ? g : 4'b0000;
            e  = '0;
            if (k == 1)
                e = mk(g, 2'(id), 1'b1, 1'b0, 1'b0, issueMode, op == MODE_SHIFT_OUT || op == MODE_SHIFT_IN);
            else if (k > 1 && k < doneAt)
                e = mk(g, 2'(id), 1'b1, 1'b0, 1'b0, op, 1'b0);
            else if (k == doneAt)
                e = mk(g, 2'(id), 1'b1, 1'b1, expErr, 2'd0, 1'b0);
            applyStimulus(1'b0, rq, opv, k == finAt);
            checkOutput(e, $sformatf("%s_k%0d", tag, k));
        end
    endtask

    // All four request SHIFT_IN continuously; the converter answers 10 cycles
    // after each start, so every transfer takes 13 cycles including IDLE.
    task automatic runRoundRobin();
        int         j;
        int         p;
        logic [3:0] g;
        logic [3:0] rq;
        out_t       e;
        for (int k = 0; k <= 13 * 5; k++) begin
            j  = k / 13;
            p  = k % 13;
            g  = 4'(1) << (j % 4);
            rq = (j == 5 || (j == 4 && p == 12)) ? 4'b0000 : 4'b1111;
            e  = '0;
            if (j < 5) begin
                if (p == 1)
                    e = mk(g, 2'(j % 4), 1'b1, 1'b0, 1'b0, MODE_SHIFT_IN, 1'b1);
                else if (p >= 2 && p <= 11)
                    e = mk(g, 2'(j % 4), 1'b1, 1'b0, 1'b0, MODE_SHIFT_IN, 1'b0);
                else if (p == 12)
                    e = mk(g, 2'(j % 4), 1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
            end
            applyStimulus(1'b0, rq, 8'b0101_0101, p == 11 && j < 5);
            checkOutput(e, $sformatf("rr_t%0d_p%0d", j, p));
        end
    endtask

    // Reset during RUN abandons the transfer and returns the pointer to 0.
    task automatic runResetMidRun();
        out_t zero;
        zero = '0;
        applyStimulus(1'b0, 4'b0010, 8'b0000_0100, 1'b0);
        checkOutput(zero, "rst_idle");
        applyStimulus(1'b0, 4'b0010, 8'b0000_0100, 1'b0);
        checkOutput(mk(4'b0010, 2'd1, 1'b1, 1'b0, 1'b0, MODE_SHIFT_IN, 1'b1), "rst_issue");
        for (int k = 2; k <= 5; k++) begin
            applyStimulus(k == 5, (k == 5) ? 4'b0000 : 4'b0010, 8'b0000_0100, 1'b0);
            checkOutput(mk(4'b0010, 2'd1, 1'b1, 1'b0, 1'b0, MODE_SHIFT_IN, 1'b0),
                        $sformatf("rst_run%0d", k));
        end
        applyStimulus(1'b0, 4'b0000, 8'h00, 1'b0);
        checkOutput(zero, "reset_mid_run");
        applyStimulus(1'b0, 4'b0000, 8'h00, 1'b1);
        checkOutput(zero, "stray_finish_idle");
        applyStimulus(1'b0, 4'b0000, 8'h00, 1'b0);
        checkOutput(zero, "post_rst_idle");
        applyStimulus(1'b0, 4'b1010, 8'hAA, 1'b0);
        checkOutput(zero, "post_rst_req");
        applyStimulus(1'b0, 4'b1010, 8'hAA, 1'b0);
        checkOutput(mk(4'b0010, 2'd1, 1'b1, 1'b0, 1'b0, MODE_PLOAD, 1'b0), "ptr_reset_grant");
        applyStimulus(1'b0, 4'b0000, 8'hAA, 1'b0);
        checkOutput(mk(4'b0010, 2'd1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0), "ptr_reset_done");
        applyStimulus(1'b0, 4'b0000, 8'h00, 1'b0);
        checkOutput(zero, "final_idle");
    endtask

    initial begin
        out_t z;
        z = '0;
        vecs[0]  = mkVec(1'b0, 4'b0000, 8'h00, 1'b0, z);
        vecs[1]  = mkVec(1'b0, 4'b0000, 8'h00, 1'b0, z);
        vecs[2]  = mkVec(1'b0, 4'b0000, 8'h00, 1'b0, z);
        vecs[3]  = mkVec(1'b0, 4'b0000, 8'h00, 1'b0, z);
        vecs[4]  = mkVec(1'b0, 4'b0000, 8'h00, 1'b1, z);
        vecs[5]  = mkVec(1'b0, 4'b0010, 8'h08, 1'b0, z);
        vecs[6]  = mkVec(1'b0, 4'b0010, 8'h08, 1'b0, mk(4'b0010, 2'd1, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0));
        vecs[7]  = mkVec(1'b0, 4'b0000, 8'h08, 1'b0, mk(4'b0010, 2'd1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0));
        vecs[8]  = mkVec(1'b0, 4'b0100, 8'h30, 1'b0, z);
        vecs[9]  = mkVec(1'b0, 4'b0100, 8'h30, 1'b1, mk(4'b0100, 2'd2, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0));
        vecs[10] = mkVec(1'b0, 4'b0000, 8'h30, 1'b0, mk(4'b0100, 2'd2, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0));
        vecs[11] = mkVec(1'b0, 4'b0011, 8'hAA, 1'b0, z);
        vecs[12] = mkVec(1'b0, 4'b0011, 8'hFF, 1'b0, mk(4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0));
        vecs[13] = mkVec(1'b0, 4'b0011, 8'hAA, 1'b0, mk(4'b0001, 2'd0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0));
        vecs[14] = mkVec(1'b0, 4'b0011, 8'hAA, 1'b0, z);
        vecs[15] = mkVec(1'b0, 4'b0011, 8'hAA, 1'b0, mk(4'b0010, 2'd1, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0));
        vecs[16] = mkVec(1'b0, 4'b0011, 8'hAA, 1'b0, mk(4'b0010, 2'd1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0));
        vecs[17] = mkVec(1'b0, 4'b0011, 8'hAA, 1'b0, z);
        vecs[18] = mkVec(1'b0, 4'b0001, 8'hAA, 1'b0, mk(4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0));
        vecs[19] = mkVec(1'b0, 4'b0000, 8'hAA, 1'b0, mk(4'b0001, 2'd0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0));
        vecs[20] = mkVec(1'b0, 4'b0000, 8'h00, 1'b0, z);

        reset       = 1'b1;
        req         = '0;
        req_op      = '0;
        conv_finish = 1'b0;
        repeat (3) @(posedge clk);

        $display("[TB] table vectors");
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].req, vecs[i].op, vecs[i].fin);
            checkOutput(vecs[i].exp, $sformatf("vec%0d", i));
        end

        $display("[TB] converter sequences");
        runTransfer(0, MODE_SHIFT_OUT, 11, 12, 1'b0, "shift_out_nominal");
        runTransfer(2, MODE_SHIFT_IN, 11, 12, 1'b0, "shift_in_nominal");
        runTransfer(3, MODE_SHIFT_IN, -1, 21, 1'b1, "timeout");
        runTransfer(3, MODE_SHIFT_OUT, 20, 21, 1'b0, "timeout_vs_finish");
        runTransfer(3, MODE_SHIFT_OUT, 19, 20, 1'b0, "finish_before_timeout");

        $display("[TB] round robin");
        runRoundRobin();

        $display("[TB] reset during RUN");
        runResetMidRun();

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
